// File: rtl/pmem_pkg.sv
`timescale 1ns/1ps
// pmem_pkg: shared types for the physical-memory bridge, plus the word-level
// memory reached through pmem_read/pmem_write (64-bit words, byte masks).
package pmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {GNT_I, GNT_D} gnt_t;

    // Sparse word store keyed by 8-byte-aligned address; absent words read as 0.
    logic [63:0] pmem_mem [logic [63:0]];
    int unsigned pmem_rd_calls;
    int unsigned pmem_wr_calls;

    function automatic longint pmem_read(input longint addr, input bit en);
        logic [63:0] key;
        if (!en) return 64'd0;
        pmem_rd_calls++;
        key = addr & ~64'h7;
        if (pmem_mem.exists(key)) return longint'(pmem_mem[key]);
        return 64'd0;
    endfunction

    function automatic void pmem_write(input longint addr, input longint wdata,
                                       input byte wmask, input bit en);
        logic [63:0] key;
        logic [63:0] d;
        logic [63:0] w;
        if (!en) return;
        pmem_wr_calls++;
        key = addr & ~64'h7;
        d   = wdata;
        w   = pmem_mem.exists(key) ? pmem_mem[key] : 64'd0;
        for (int b = 0; b < 8; b++)
            if (wmask[b]) w[8*b +: 8] = d[8*b +: 8];
        pmem_mem[key] = w;
    endfunction

endpackage

// File: rtl/pmem_rr_arb.sv
`timescale 1ns/1ps
// pmem_rr_arb: two-way round-robin arbiter between fetch (I) and data (D).
module pmem_rr_arb
    import pmem_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic req_d,
    input  logic advance,
    output gnt_t gnt
);

    gnt_t pointer;   // channel served most recently

    // Remember who was served on every accepted transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pointer <= GNT_I;
        else if (advance) pointer <= gnt;
    end

    // A lone requester wins; on contention the channel not served last wins
    always_comb begin
        gnt = (pointer == GNT_I) ? GNT_D : GNT_I;
        if (req_i && !req_d)      gnt = GNT_I;
        else if (req_d && !req_i) gnt = GNT_D;
    end

endmodule

// File: rtl/pmem_arb_bridge.sv
`timescale 1ns/1ps
// pmem_arb_bridge: fetch + data channels sharing one pmem_read/pmem_write port,
// one transaction in flight, fixed LATENCY cycles from accept to response.
// Optional PMEM_ERR_EN: alignment / empty-mask checks return *_err without
// touching memory.
module pmem_arb_bridge
    import pmem_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int IFETCH_W = 32,
    parameter int LATENCY  = 2
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ireq_valid,
    output logic                ireq_ready,
    input  logic [ADDR_W-1:0]   ireq_addr,
    output logic                iresp_valid,
    output logic [IFETCH_W-1:0] iresp_data,
    output logic                iresp_err,
    input  logic                dreq_valid,
    output logic                dreq_ready,
    input  logic [ADDR_W-1:0]   dreq_addr,
    input  logic                dreq_wen,
    input  logic [DATA_W-1:0]   dreq_wdata,
    input  logic [DATA_W/8-1:0] dreq_wmask,
    output logic                dresp_valid,
    output logic [DATA_W-1:0]   dresp_rdata,
    output logic                dresp_err
);

    localparam int CNT_W   = 4;
    localparam int LANES   = DATA_W / IFETCH_W;
    localparam int LANE_SH = $clog2(IFETCH_W / 8);

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt;
    gnt_t                gnt, rsp_chan;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;
    logic                idle, accept, acc_err;
    int                  lane;

    assign idle       = (state == IDLE);
    assign ireq_ready = idle && ireq_valid && (gnt == GNT_I);
    assign dreq_ready = idle && dreq_valid && (gnt == GNT_D);
    assign accept     = ireq_ready || dreq_ready;
    assign lane       = int'(32'((ireq_addr >> LANE_SH) & ADDR_W'(LANES - 1)));

    pmem_rr_arb u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (ireq_valid),
        .req_d   (dreq_valid),
        .advance (accept),
        .gnt     (gnt)
    );

`ifdef PMEM_ERR_EN
    // Misaligned address or empty write mask is rejected at accept
    always_comb begin
        acc_err = 1'b0;
        if (gnt == GNT_I)
            acc_err = |(ireq_addr & ADDR_W'(IFETCH_W / 8 - 1));
        else
            acc_err = (|(dreq_addr & ADDR_W'(DATA_W / 8 - 1))) ||
                      (dreq_wen && (dreq_wmask == '0));
    end
`else
    assign acc_err = 1'b0;
`endif

    // Select the instruction lane out of a memory word
    function automatic logic [DATA_W-1:0] pick_lane(input logic [63:0] word, input int k);
        logic [DATA_W-1:0] w;
        w = DATA_W'(word);
        return DATA_W'(w[IFETCH_W*k +: IFETCH_W]);
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Latency countdown: loaded at accept, response once it has reached zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          cnt <= '0;
        else if (accept)                     cnt <= CNT_W'(LATENCY - 1);
        else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
    end

    // Memory access happens only here, exactly once per accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_chan <= GNT_I;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (accept) begin
            rsp_chan <= gnt;
            rsp_err  <= acc_err;
            if (acc_err) begin
                rsp_data <= '0;
            end else if (gnt == GNT_I) begin
                rsp_data <= pick_lane(pmem_read(64'(ireq_addr), 1'b1), lane);
            end else if (dreq_wen) begin
                pmem_write(64'(dreq_addr), 64'(dreq_wdata), 8'(dreq_wmask), 1'b1);
                rsp_data <= '0;
            end else begin
                rsp_data <= DATA_W'(pmem_read(64'(dreq_addr), 1'b1));
            end
        end
    end

    // Next state and response outputs; data is only visible during RESP
    always_comb begin
        state_nx    = state;
        iresp_valid = 1'b0;
        iresp_data  = '0;
        iresp_err   = 1'b0;
        dresp_valid = 1'b0;
        dresp_rdata = '0;
        dresp_err   = 1'b0;
        case (state)
            IDLE: if (accept) state_nx = WAIT;
            WAIT: if (cnt == '0) state_nx = RESP;
            RESP: begin
                state_nx = IDLE;
                if (rsp_chan == GNT_I) begin
                    iresp_valid = 1'b1;
                    iresp_data  = rsp_data[IFETCH_W-1:0];
                    iresp_err   = rsp_err;
                end else begin
                    dresp_valid = 1'b1;
                    dresp_rdata = rsp_data;
                    dresp_err   = rsp_err;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pmem_arb_bridge.sv
`timescale 1ns/1ps
// tb_pmem_arb_bridge: directed checks on three bridges (LATENCY 2, 1, 15)
// sharing one clock, reset and memory.
module tb_pmem_arb_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ireq_valid [3];
    logic        ireq_ready [3];
    logic [63:0] ireq_addr  [3];
    logic        iresp_valid[3];
    logic [31:0] iresp_data [3];
    logic        iresp_err  [3];
    logic        dreq_valid [3];
    logic        dreq_ready [3];
    logic [63:0] dreq_addr  [3];
    logic        dreq_wen   [3];
    logic [63:0] dreq_wdata [3];
    logic [7:0]  dreq_wmask [3];
    logic        dresp_valid[3];
    logic [63:0] dresp_rdata[3];
    logic        dresp_err  [3];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pmem_arb_bridge #(
            .ADDR_W(64), .DATA_W(64), .IFETCH_W(32),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 15))
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .ireq_valid  (ireq_valid[g]),
            .ireq_ready  (ireq_ready[g]),
            .ireq_addr   (ireq_addr[g]),
            .iresp_valid (iresp_valid[g]),
            .iresp_data  (iresp_data[g]),
            .iresp_err   (iresp_err[g]),
            .dreq_valid  (dreq_valid[g]),
            .dreq_ready  (dreq_ready[g]),
            .dreq_addr   (dreq_addr[g]),
            .dreq_wen    (dreq_wen[g]),
            .dreq_wdata  (dreq_wdata[g]),
            .dreq_wmask  (dreq_wmask[g]),
            .dresp_valid (dresp_valid[g]),
            .dresp_rdata (dresp_rdata[g]),
            .dresp_err   (dresp_err[g])
        );
    end

    function automatic int lat_of(input int u);
        return (u == 0) ? 2 : ((u == 1) ? 1 : 15);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One request on instance u; request fields are scrambled right after accept
    task automatic xact(input int u, input bit is_i, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask,
                        input logic [63:0] exp_data, input logic exp_err, input string tag);
        int n;
        int rdy_hi;
        if (is_i) begin
            ireq_valid[u] = 1'b1; ireq_addr[u] = addr;
        end else begin
            dreq_valid[u] = 1'b1; dreq_addr[u] = addr; dreq_wen[u] = wen;
            dreq_wdata[u] = wdata; dreq_wmask[u] = wmask;
        end
        #1;
        n = 0;
        while (!(is_i ? ireq_ready[u] : dreq_ready[u]) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_ready"}, 64'(is_i ? ireq_ready[u] : dreq_ready[u]), 64'd1);
        @(posedge clk); #1;
        if (is_i) ireq_addr[u] = addr ^ 64'h4;
        else begin dreq_addr[u] = addr ^ 64'h100; dreq_wdata[u] = ~wdata; end
        n = 0; rdy_hi = 0;
        while (!(is_i ? iresp_valid[u] : dresp_valid[u]) && n < 40) begin
            if (ireq_ready[u] || dreq_ready[u]) rdy_hi++;
            @(posedge clk); #1; n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat_of(u)));
        chk({tag, "_rdy_low"}, 64'(rdy_hi), 64'd0);
        if (is_i) begin
            chk({tag, "_data"}, 64'(iresp_data[u]), 64'(exp_data[31:0]));
            chk({tag, "_err"}, 64'(iresp_err[u]), 64'(exp_err));
            chk({tag, "_other"}, 64'(dresp_valid[u]), 64'd0);
            ireq_valid[u] = 1'b0;
        end else begin
            chk({tag, "_data"}, dresp_rdata[u], exp_data);
            chk({tag, "_err"}, 64'(dresp_err[u]), 64'(exp_err));
            chk({tag, "_other"}, 64'(iresp_valid[u]), 64'd0);
            dreq_valid[u] = 1'b0;
        end
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'(is_i ? iresp_valid[u] : dresp_valid[u]), 64'd0);
        chk({tag, "_data_off"}, is_i ? 64'(iresp_data[u]) : dresp_rdata[u], 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c_rd, c_wr;
        int n, ngnt, nrsp, ovl;
        bit drop;
        logic gseq [8];

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ireq_valid[i] = 1'b0; ireq_addr[i] = '0;
            dreq_valid[i] = 1'b0; dreq_addr[i] = '0; dreq_wen[i] = 1'b0;
            dreq_wdata[i] = '0;   dreq_wmask[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_iready", 64'(ireq_ready[0]), 64'd0);
        chk("rst_dready", 64'(dreq_ready[0]), 64'd0);
        chk("rst_ivalid", 64'(iresp_valid[0]), 64'd0);
        chk("rst_idata",  64'(iresp_data[0]), 64'd0);
        chk("rst_ierr",   64'(iresp_err[0]), 64'd0);
        chk("rst_dvalid", 64'(dresp_valid[0]), 64'd0);
        chk("rst_ddata",  dresp_rdata[0], 64'd0);
        chk("rst_derr",   64'(dresp_err[0]), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic traffic: preload, fetch upper lane, masked write merge, read back
        c_rd = pmem_pkg::pmem_rd_calls; c_wr = pmem_pkg::pmem_wr_calls;
        xact(0, 0, 1, 64'h8000_0000, 64'h1111_2222_3333_4444, 8'hFF, 64'h0, 1'b0, "wr_base");
        xact(0, 1, 0, 64'h8000_0004, 64'h0, 8'h0, 64'h1111_2222, 1'b0, "fetch_hi");
        xact(0, 0, 1, 64'h8000_0100, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF, 64'h0, 1'b0, "wr_full");
        xact(0, 0, 1, 64'h8000_0100, 64'hDEAD_BEEF_0000_0001, 8'h0F, 64'h0, 1'b0, "wr_mask");
        xact(0, 0, 0, 64'h8000_0100, 64'h0, 8'h0, 64'hAAAA_BBBB_0000_0001, 1'b0, "rd_merge");
        chk("calls_wr", 64'(pmem_pkg::pmem_wr_calls - c_wr), 64'd3);
        chk("calls_rd", 64'(pmem_pkg::pmem_rd_calls - c_rd), 64'd2);

        // Idle bridge must not touch memory
        c_rd = pmem_pkg::pmem_rd_calls; c_wr = pmem_pkg::pmem_wr_calls;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_calls", 64'((pmem_pkg::pmem_rd_calls - c_rd) + (pmem_pkg::pmem_wr_calls - c_wr)), 64'd0);

        // Misaligned fetch
        c_rd = pmem_pkg::pmem_rd_calls;
`ifdef PMEM_ERR_EN
        xact(0, 1, 0, 64'h8000_0002, 64'h0, 8'h0, 64'h0, 1'b1, "fetch_misal");
        chk("misal_calls", 64'(pmem_pkg::pmem_rd_calls - c_rd), 64'd0);
`else
        xact(0, 1, 0, 64'h8000_0002, 64'h0, 8'h0, 64'h3333_4444, 1'b0, "fetch_misal");
        chk("misal_calls", 64'(pmem_pkg::pmem_rd_calls - c_rd), 64'd1);
`endif

        // Latency extremes
        xact(1, 1, 0, 64'h8000_0000, 64'h0, 8'h0, 64'h3333_4444, 1'b0, "lat1_fetch");
        xact(2, 0, 0, 64'h8000_0100, 64'h0, 8'h0, 64'hAAAA_BBBB_0000_0001, 1'b0, "lat15_rd");

        // Reset while a read is waiting
        dreq_valid[0] = 1'b1; dreq_wen[0] = 1'b0; dreq_addr[0] = 64'h8000_0100;
        #1;
        chk("rstop_ready", 64'(dreq_ready[0]), 64'd1);
        @(posedge clk); #1;
        dreq_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstop_dvalid", 64'(dresp_valid[0]), 64'd0);
        chk("rstop_ddata",  dresp_rdata[0], 64'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (dresp_valid[0] || iresp_valid[0]) n++;
        end
        chk("rstop_no_resp", 64'(n), 64'd0);

        // Both channels requesting continuously: grants alternate starting with D
        c_rd = pmem_pkg::pmem_rd_calls;
        ireq_valid[0] = 1'b1; ireq_addr[0] = 64'h8000_0004;
        dreq_valid[0] = 1'b1; dreq_wen[0] = 1'b0; dreq_addr[0] = 64'h8000_0000;
        ngnt = 0; nrsp = 0; ovl = 0; n = 0; drop = 1'b0;
        for (int k = 0; k < 8; k++) gseq[k] = 1'b0;
        while (nrsp < 8 && n < 120) begin
            @(negedge clk);
            if (drop) begin ireq_valid[0] = 1'b0; dreq_valid[0] = 1'b0; end
            if (ireq_ready[0] && dreq_ready[0]) ovl++;
            if (iresp_valid[0] && dresp_valid[0]) ovl++;
            if (iresp_valid[0] || dresp_valid[0]) nrsp++;
            if (ngnt < 8 && (dreq_ready[0] || ireq_ready[0])) begin
                gseq[ngnt] = dreq_ready[0];
                ngnt++;
                if (ngnt == 8) drop = 1'b1;
            end
            n++;
        end
        ireq_valid[0] = 1'b0; dreq_valid[0] = 1'b0;
        for (int k = 0; k < 8; k++)
            chk($sformatf("arb_gnt%0d", k), 64'(gseq[k]), (k % 2 == 0) ? 64'd1 : 64'd0);
        chk("arb_grants", 64'(ngnt), 64'd8);
        chk("arb_resps", 64'(nrsp), 64'd8);
        chk("arb_overlap", 64'(ovl), 64'd0);
        chk("arb_calls", 64'(pmem_pkg::pmem_rd_calls - c_rd), 64'd8);
        @(posedge clk); #1;

        xact(0, 0, 0, 64'h8000_0100, 64'h0, 8'h0, 64'hAAAA_BBBB_0000_0001, 1'b0, "rd_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
        $finish;
    end

endmodule
